ps2_send: RTL
=============

PS2_SEND -- requirements
Module: ps2_send

Interface
REQ-001 Parameter CLK_HZ, 50000000, clock50 frequency in Hz; all cycle counts derive from it.
REQ-002 Parameter INHIBIT_US, 120, PS/2 clock-low request time in microseconds.
REQ-003 Parameter START_TIMEOUT_US, 15000, maximum wait from clock release to first device falling edge.
REQ-004 Parameter PACKET_TIMEOUT_US, 2000, maximum time from first device falling edge to line-idle after ACK.
REQ-005 clock50  in  1  sole clock; all logic on its rising edge.
REQ-006 reset  in  1  synchronous, active-high reset.
REQ-007 ps2_clk_i  in  1  raw PS2_CLK pin level (asynchronous).
REQ-008 ps2_dat_i  in  1  raw PS2_DAT pin level (asynchronous).
REQ-009 ps2_clk_oe  out  1  1 = drive PS2_CLK low; 0 = release (top level ties pin to Z).
REQ-010 ps2_dat_oe  out  1  1 = drive PS2_DAT low; 0 = release.
REQ-011 tx_data  in  8  command byte to the keyboard, sampled on the tx_start cycle.
REQ-012 tx_start  in  1  one-cycle request strobe.
REQ-013 tx_busy  out  1  1 from cycle after accepted tx_start until return to IDLE.
REQ-014 tx_done  out  1  one-cycle pulse: byte sent and ACK seen.
REQ-015 tx_error  out  1  one-cycle pulse: NACK or timeout.
REQ-016 rx_inhibit  out  1  equals tx_busy; the keyboard receiver discards bits while high.

Function
REQ-017 Inputs pass through a 2-flop synchronizer; a device falling edge is a 1->0 transition of synchronized clock; edge detect adds 1 cycle.
REQ-018 States: IDLE, INHIBIT, RELEASE, SHIFT, ACK, WAITIDLE; all outputs registered.
REQ-019 IDLE: tx_start=1 latches tx_data and parity = ~^tx_data (odd), clears counters, enters INHIBIT; tx_start in any other state is ignored.
REQ-020 INHIBIT: clk_oe=1 for INHIBIT_CYC = CLK_HZ/1000000*INHIBIT_US cycles (6000 at defaults); dat_oe=1 on the final cycle (start bit).
REQ-021 RELEASE: clk_oe=0, dat_oe=1; wait for first falling edge, limit START_TIMEOUT_CYC (750000 at defaults).
REQ-022 SHIFT: edge counter 1..10; edges 1-8 drive data bits 0-7 LSB first (dat_oe = ~bit), edge 9 drives parity, edge 10 releases data (stop).
REQ-023 ACK: at edge 11 sample synchronized data: 0 = ACK, 1 = NACK.
REQ-024 WAITIDLE: after ACK wait until synchronized clock and data both high, then tx_done pulse, return IDLE.
REQ-025 NACK: tx_error pulse, return IDLE without tx_done.
REQ-026 Packet timer runs from first edge through WAITIDLE; reaching PACKET_TIMEOUT_CYC (100000) -> both oe=0, tx_error pulse, IDLE.
REQ-027 tx_done and tx_error are never asserted in the same cycle; exactly one fires per accepted request.
REQ-028 Timeout counters are 20 bits; they saturate and never wrap.

Reset
REQ-029 After a reset cycle: ps2_clk_oe=0, ps2_dat_oe=0, tx_busy=0, tx_done=0, tx_error=0, state IDLE, counters 0.
REQ-030 Reset mid-operation releases both lines on the next edge, aborts the byte, and produces no done or error pulse.

Configuration
REQ-031 Macro PS2_SEND_FILTER_EN: when defined, the synchronized clock passes an 8-sample majority-free filter (level changes only after 8 equal consecutive samples, +8 cycles latency); when undefined, no filter and behaviour per REQ-017.

Structure
REQ-032 Shared package ps2_pkg holds the state encoding, the ACK/NACK level constants and the microsecond-to-cycle conversion function.
REQ-033 Sub-module ps2_sync implements the synchronizer, optional filter and falling-edge detect; the keyboard receiver reuses it.

Verification
REQ-034 Reset asserted 2 cycles -> both oe=0, tx_busy=0, no pulses.
REQ-035 tx_start with 0xED, device model at 12.5 kHz ACKs -> clk_oe low 6000 cycles; bits 1,0,1,1,0,1,1,1; parity 1; tx_done once; tx_error never.
REQ-036 tx_start with 0x07, device holds data high at edge 11 -> parity 0 sent; tx_error pulse; no tx_done.
REQ-037 tx_start with no device clocks -> tx_error exactly 750000 cycles after RELEASE entry (+sync latency); both lines released.
REQ-038 Second tx_start during SHIFT is ignored; reset asserted during SHIFT bit 4 -> oe=0 and tx_busy=0 next cycle; a new 0xF4 then completes normally.
REQ-039 With PS2_SEND_FILTER_EN, a 3-cycle low glitch on the clock line is not counted as an edge; without it, the same glitch advances the bit counter.

Source files
------------

// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 host transmitter and receiver.
// Holds the FSM encoding, bus level constants and the us-to-cycles helper.
package ps2_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_INHIBIT,
      S_RELEASE,
      S_SHIFT,
      S_ACK,
      S_WAITIDLE
   } state_t;

   localparam logic ACK_LVL  = 1'b0;
   localparam logic NACK_LVL = 1'b1;

   localparam int unsigned CNT_W = 20;
   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   function automatic logic [CNT_W-1:0] us2cyc(
      input int unsigned hz,
      input int unsigned us
   );
      return CNT_W'(hz / 1000000 * us);
   endfunction

endpackage

// File: rtl/ps2_sync.sv
// ps2_sync: 2-flop synchronizer, optional settle filter, falling-edge strobe.
// Build macro PS2_SEND_FILTER_EN enables the 8-sample level filter.
module ps2_sync
   import ps2_pkg::*;
(
   input  logic clk_i,
   input  logic rst_i,
   input  logic raw_i,
   output logic level_o,
   output logic fall_o
);

   logic s1_q;
   logic s2_q;
   logic lvl;
   logic prev_q;
   logic fall_q;

   // two-flop synchronizer; resets high like an idle bus
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         s1_q <= 1'b1;
         s2_q <= 1'b1;
      end else begin
         s1_q <= raw_i;
         s2_q <= s1_q;
      end
   end

`ifdef PS2_SEND_FILTER_EN
   logic [2:0] run_q;
   logic       filt_q;

   // level follows the pin only after 8 consecutive differing samples
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         run_q  <= 3'd0;
         filt_q <= 1'b1;
      end else if (s2_q == filt_q) begin
         run_q <= 3'd0;
      end else if (run_q == 3'd7) begin
         run_q  <= 3'd0;
         filt_q <= s2_q;
      end else begin
         run_q <= run_q + 3'd1;
      end
   end

   assign lvl = filt_q;
`else
   assign lvl = s2_q;
`endif

   // registered 1->0 strobe on the settled level
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         prev_q <= 1'b1;
         fall_q <= 1'b0;
      end else begin
         prev_q <= lvl;
         fall_q <= prev_q & ~lvl;
      end
   end

   assign level_o = lvl;
   assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_send.sv
// ps2_send: host-to-keyboard byte transmitter with ACK/NACK and timeouts.
// Build macro PS2_SEND_FILTER_EN selects the filtered clock in ps2_sync.
module ps2_send
   import ps2_pkg::*;
#(
   parameter int unsigned CLK_HZ            = 50000000,
   parameter int unsigned INHIBIT_US        = 120,
   parameter int unsigned START_TIMEOUT_US  = 15000,
   parameter int unsigned PACKET_TIMEOUT_US = 2000
) (
   input  logic       clock50,
   input  logic       reset,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   output logic       rx_inhibit
);

   localparam logic [CNT_W-1:0] INH_CYC =
      us2cyc(CLK_HZ, INHIBIT_US);
   localparam logic [CNT_W-1:0] START_CYC =
      us2cyc(CLK_HZ, START_TIMEOUT_US);
   localparam logic [CNT_W-1:0] PKT_CYC =
      us2cyc(CLK_HZ, PACKET_TIMEOUT_US);

   localparam logic [CNT_W-1:0] INH_LAST   = INH_CYC - 20'd1;
   localparam logic [CNT_W-1:0] INH_DAT    = INH_CYC - 20'd2;
   localparam logic [CNT_W-1:0] START_LAST = START_CYC - 20'd1;
   localparam logic [CNT_W-1:0] PKT_LAST   = PKT_CYC - 20'd1;

   state_t           state_q;
   logic             clk_oe_q;
   logic             dat_oe_q;
   logic             busy_q;
   logic             done_q;
   logic             err_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;
   logic [CNT_W-1:0] pkt_q;
   logic [CNT_W-1:0] pkt_d;
   logic [3:0]       bit_q;
   logic [7:0]       data_q;
   logic             par_q;
   logic             dat_s1_q;
   logic             dat_s2_q;
   logic             clk_s;
   logic             clk_fall;
   logic             pkt_exp;

   ps2_sync u_clk_sync (
      .clk_i   (clock50),
      .rst_i   (reset),
      .raw_i   (ps2_clk_i),
      .level_o (clk_s),
      .fall_o  (clk_fall)
   );

   // data line only needs plain synchronization
   always_ff @(posedge clock50) begin
      if (reset) begin
         dat_s1_q <= 1'b1;
         dat_s2_q <= 1'b1;
      end else begin
         dat_s1_q <= ps2_dat_i;
         dat_s2_q <= dat_s1_q;
      end
   end

   // saturating next values for both timers
   always_comb begin
      cnt_d = cnt_q;
      pkt_d = pkt_q;
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 20'd1;
      if (pkt_q != CNT_MAX) pkt_d = pkt_q + 20'd1;
   end

   assign pkt_exp = (pkt_q == PKT_LAST);

   // transmit FSM; every output is a register
   always_ff @(posedge clock50) begin
      if (reset) begin
         state_q  <= S_IDLE;
         clk_oe_q <= 1'b0;
         dat_oe_q <= 1'b0;
         busy_q   <= 1'b0;
         done_q   <= 1'b0;
         err_q    <= 1'b0;
         cnt_q    <= '0;
         pkt_q    <= '0;
         bit_q    <= 4'd0;
         data_q   <= 8'd0;
         par_q    <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         unique case (state_q)
            S_IDLE: begin
               if (tx_start) begin
                  data_q   <= tx_data;
                  par_q    <= ~^tx_data;
                  cnt_q    <= '0;
                  pkt_q    <= '0;
                  bit_q    <= 4'd0;
                  clk_oe_q <= 1'b1;
                  busy_q   <= 1'b1;
                  state_q  <= S_INHIBIT;
               end
            end
            S_INHIBIT: begin
               cnt_q <= cnt_d;
               if (cnt_q == INH_LAST) begin
                  clk_oe_q <= 1'b0;
                  cnt_q    <= '0;
                  state_q  <= S_RELEASE;
               end else if (cnt_q == INH_DAT) begin
                  dat_oe_q <= 1'b1;
               end
            end
            S_RELEASE: begin
               cnt_q <= cnt_d;
               if (clk_fall) begin
                  bit_q    <= 4'd1;
                  dat_oe_q <= ~data_q[0];
                  pkt_q    <= '0;
                  state_q  <= S_SHIFT;
               end else if (cnt_q == START_LAST) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  busy_q   <= 1'b0;
                  err_q    <= 1'b1;
                  state_q  <= S_IDLE;
               end
            end
            S_SHIFT: begin
               pkt_q <= pkt_d;
               if (pkt_exp) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  busy_q   <= 1'b0;
                  err_q    <= 1'b1;
                  state_q  <= S_IDLE;
               end else if (clk_fall) begin
                  bit_q <= bit_q + 4'd1;
                  unique case (1'b1)
                     (bit_q < 4'd8):
                        dat_oe_q <= ~data_q[bit_q[2:0]];
                     (bit_q == 4'd8):
                        dat_oe_q <= ~par_q;
                     default: begin
                        dat_oe_q <= 1'b0;
                        state_q  <= S_ACK;
                     end
                  endcase
               end
            end
            S_ACK: begin
               pkt_q <= pkt_d;
               if (pkt_exp) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  busy_q   <= 1'b0;
                  err_q    <= 1'b1;
                  state_q  <= S_IDLE;
               end else if (clk_fall) begin
                  if (dat_s2_q == ACK_LVL) begin
                     state_q <= S_WAITIDLE;
                  end else begin
                     busy_q  <= 1'b0;
                     err_q   <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
            end
            S_WAITIDLE: begin
               pkt_q <= pkt_d;
               if (pkt_exp) begin
                  clk_oe_q <= 1'b0;
                  dat_oe_q <= 1'b0;
                  busy_q   <= 1'b0;
                  err_q    <= 1'b1;
                  state_q  <= S_IDLE;
               end else if (clk_s && dat_s2_q) begin
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                  state_q <= S_IDLE;
               end
            end
            default: begin
               clk_oe_q <= 1'b0;
               dat_oe_q <= 1'b0;
               busy_q   <= 1'b0;
               state_q  <= S_IDLE;
            end
         endcase
      end
   end

   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;
   assign tx_busy    = busy_q;
   assign rx_inhibit = busy_q;
   assign tx_done    = done_q;
   assign tx_error   = err_q;

endmodule
